// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM tape-port arbiter.
// Used by the top level and by the round-robin picker.
package sdram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } arb_state_e;

  localparam int SDRAM_AW = 23;
  localparam int BYTE_W = 8;
  localparam logic [1:0] TAPE_BANK = 2'b10;

endpackage

// File: rtl/sdram_tape_arb_rr_pick.sv
// Round-robin priority picker: scans from last+1 upward, wrapping,
// and returns the first requester found.
module rr_pick
  import sdram_pkg::*;
#(
  parameter int N_CLIENTS = 3
) (
  input  logic [N_CLIENTS-1:0] req,
  input  logic [1:0]           last,
  output logic [N_CLIENTS-1:0] gnt,
  output logic [1:0]           idx,
  output logic                 any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 1; k <= N_CLIENTS; k++) begin
      j = (int'(last) + k) % N_CLIENTS;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = 2'(j);
      end
    end
  end

endmodule

// File: rtl/sdram_tape_arb.sv
// Arbitrates byte-wide tape/loader clients onto the SDRAM tape port,
// translating level-req/pulse-ack into level rd/wr with toggle/pulse acks.
module sdram_tape_arb
  import sdram_pkg::*;
#(
  parameter int N_CLIENTS = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [N_CLIENTS-1:0]          c_req,
  input  logic [N_CLIENTS-1:0]          c_we,
  input  logic [N_CLIENTS*SDRAM_AW-1:0] c_addr,
  input  logic [N_CLIENTS*BYTE_W-1:0]   c_din,
  output logic [N_CLIENTS-1:0]          c_ack,
  output logic                          c_err,
  output logic [BYTE_W-1:0]             c_dout,
  output logic [1:0]                    grant_id,
  output logic                          busy,
  output logic [SDRAM_AW-1:0]           tape_addr,
  output logic [BYTE_W-1:0]             tape_din,
  input  logic [BYTE_W-1:0]             tape_dout,
  output logic                          tape_wr,
  input  logic                          tape_wr_ack,
  output logic                          tape_rd,
  input  logic                          tape_rd_ack
);

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  arb_state_e state_q, state_d;

  logic [N_CLIENTS-1:0] c_ack_q, c_ack_d;
  logic                 c_err_q, c_err_d;
  logic [BYTE_W-1:0]    c_dout_q, c_dout_d;
  logic [1:0]           grant_id_q, grant_id_d;
  logic [SDRAM_AW-1:0]  tape_addr_q, tape_addr_d;
  logic [BYTE_W-1:0]    tape_din_q, tape_din_d;
  logic                 ack_expect_q, ack_expect_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;

  logic [N_CLIENTS-1:0] pick_gnt;
  logic [1:0]           pick_idx;
  logic                 pick_any;
  logic                 pick_we;
  logic                 rd_done, wr_done, tmo_hit, abort;
  logic [N_CLIENTS-1:0] ack_onehot;

  rr_pick #(.N_CLIENTS(N_CLIENTS)) u_pick (
    .req  (c_req),
    .last (grant_id_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign pick_we    = |(c_we & pick_gnt);
  assign ack_onehot = N_CLIENTS'(1) << grant_id_q;
  // A toggle on rd_ack (relative to the expected parity) marks read completion.
  assign rd_done    = (state_q == RD) && (tape_rd_ack != ack_expect_q);
  assign wr_done    = (state_q == WR) && tape_wr_ack;
  assign tmo_hit    = (TIMEOUT != 0) && ((state_q == RD) || (state_q == WR)) &&
                      (tmo_q == TMO_W'(TIMEOUT - 1));
  assign abort      = tmo_hit && !rd_done && !wr_done;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      c_ack_q      <= '0;
      c_err_q      <= 1'b0;
      c_dout_q     <= '0;
      grant_id_q   <= 2'(N_CLIENTS - 1);
      tape_addr_q  <= '0;
      tape_din_q   <= '0;
      ack_expect_q <= tape_rd_ack;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      c_ack_q      <= c_ack_d;
      c_err_q      <= c_err_d;
      c_dout_q     <= c_dout_d;
      grant_id_q   <= grant_id_d;
      tape_addr_q  <= tape_addr_d;
      tape_din_q   <= tape_din_d;
      ack_expect_q <= ack_expect_d;
      tmo_q        <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (pick_any) state_d = pick_we ? WR : RD;
      RD:   if (rd_done || tmo_hit) state_d = DONE;
      WR:   if (wr_done || tmo_hit) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    c_ack_d      = '0;
    c_err_d      = 1'b0;
    c_dout_d     = c_dout_q;
    grant_id_d   = grant_id_q;
    tape_addr_d  = tape_addr_q;
    tape_din_d   = tape_din_q;
    ack_expect_d = ack_expect_q;
    tmo_d        = tmo_q;
    if (state_q == IDLE && pick_any) begin
      grant_id_d  = pick_idx;
      tape_addr_d = c_addr[int'(pick_idx)*SDRAM_AW +: SDRAM_AW];
      tape_din_d  = c_din[int'(pick_idx)*BYTE_W +: BYTE_W];
      tmo_d       = '0;
    end else if (state_q == RD || state_q == WR) begin
      tmo_d = tmo_q + 1'b1;
    end
    if (rd_done) begin
      c_dout_d     = tape_dout;
      ack_expect_d = ~ack_expect_q;
      c_ack_d      = ack_onehot;
    end else if (wr_done) begin
      c_ack_d = ack_onehot;
    end else if (abort) begin
      // Resync parity so a stray toggle cannot complete the next read.
      c_ack_d      = ack_onehot;
      c_err_d      = 1'b1;
      ack_expect_d = tape_rd_ack;
    end
  end

  always_comb begin
    tape_rd = (state_q == RD) && (tape_rd_ack == ack_expect_q);
    tape_wr = (state_q == WR) && !tape_wr_ack;
    busy    = (state_q != IDLE);
  end

  assign c_ack     = c_ack_q;
  assign c_err     = c_err_q;
  assign c_dout    = c_dout_q;
  assign grant_id  = grant_id_q;
  assign tape_addr = tape_addr_q;
  assign tape_din  = tape_din_q;

endmodule

// File: tb/tb_sdram_tape_arb.sv
// Scoreboard bench for sdram_tape_arb with a small SDRAM tape-port responder.
module tb_sdram_tape_arb;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  c_req, c_we;
  logic [N*23-1:0] c_addr;
  logic [N*8-1:0]  c_din;
  logic [N-1:0]  c_ack;
  logic          c_err;
  logic [7:0]    c_dout;
  logic [1:0]    grant_id;
  logic          busy;
  logic [22:0]   tape_addr;
  logic [7:0]    tape_din;
  logic [7:0]    tape_dout = 8'h00;
  logic          tape_wr;
  logic          tape_wr_ack = 1'b0;
  logic          tape_rd;
  logic          tape_rd_ack = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          gid;
    logic        err;
    logic [7:0]  dout;
    logic [22:0] addr;
    logic [7:0]  din;
    logic        we;
  } exp_t;
  exp_t sb[$];

  logic [7:0] last_dout = 8'h00;
  logic [7:0] rd_data = 8'h00;
  int  rd_delay = 5, wr_delay = 3;
  bit  ack_en = 1'b1;
  int  rd_cnt = 0, wr_cnt = 0;
  int  wr_rise = 0;
  logic prev_rd_ack = 1'b1, prev_wr = 1'b0;

  sdram_tape_arb #(.N_CLIENTS(N), .TIMEOUT(20)) dut (
    .clk(clk), .reset_n(reset_n), .c_req(c_req), .c_we(c_we),
    .c_addr(c_addr), .c_din(c_din), .c_ack(c_ack), .c_err(c_err),
    .c_dout(c_dout), .grant_id(grant_id), .busy(busy),
    .tape_addr(tape_addr), .tape_din(tape_din), .tape_dout(tape_dout),
    .tape_wr(tape_wr), .tape_wr_ack(tape_wr_ack), .tape_rd(tape_rd),
    .tape_rd_ack(tape_rd_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // SDRAM responder; not reset, like the real controller.
  always @(posedge clk) begin
    tape_wr_ack <= 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt <= rd_cnt - 1;
      if (rd_cnt == 1) begin
        tape_rd_ack <= ~tape_rd_ack;
        tape_dout   <= rd_data;
      end
    end else if (tape_rd && ack_en) begin
      rd_cnt <= rd_delay;
    end
    if (wr_cnt > 0) begin
      wr_cnt <= wr_cnt - 1;
      if (wr_cnt == 1) tape_wr_ack <= 1'b1;
    end else if (tape_wr && ack_en) begin
      wr_cnt <= wr_delay;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (tape_rd_ack != prev_rd_ack) chk("rd_gate", 32'(tape_rd), 0);
    prev_rd_ack = tape_rd_ack;
    if (tape_wr_ack) chk("wr_gate", 32'(tape_wr), 0);
    if (tape_wr && !prev_wr) wr_rise++;
    prev_wr = tape_wr;
    if (c_err && c_ack == '0) chk("err_alone", 32'(c_err), 0);
    if (c_ack != '0) begin
      if (sb.size() == 0) begin
        chk("unexp_ack", 32'(c_ack), 0);
      end else begin
        e = sb.pop_front();
        chk("ack_vec", 32'(c_ack), 32'(1) << e.gid);
        chk("ack_err", 32'(c_err), 32'(e.err));
        chk("ack_dout", 32'(c_dout), 32'(e.dout));
        chk("ack_gid", 32'(grant_id), 32'(e.gid));
        chk("ack_addr", 32'(tape_addr), 32'(e.addr));
        if (e.we) chk("ack_din", 32'(tape_din), 32'(e.din));
        chk("done_wr", 32'(tape_wr), 0);
        chk("done_rd", 32'(tape_rd), 0);
        chk("done_busy", 32'(busy), 1);
      end
    end
  end

  task automatic reset_checks();
    chk("rst_ack", 32'(c_ack), 0);
    chk("rst_err", 32'(c_err), 0);
    chk("rst_dout", 32'(c_dout), 0);
    chk("rst_gid", 32'(grant_id), N - 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd", 32'(tape_rd), 0);
    chk("rst_wr", 32'(tape_wr), 0);
    chk("rst_addr", 32'(tape_addr), 0);
    chk("rst_din", 32'(tape_din), 0);
  endtask

  task automatic push_exp(input int ci, input bit we, input logic [22:0] addr,
                          input logic [7:0] din, input bit err);
    exp_t e;
    e.gid = ci; e.err = err; e.addr = addr; e.din = din; e.we = we;
    if (!we && !err) last_dout = rd_data;
    e.dout = last_dout;
    sb.push_back(e);
  endtask

  task automatic do_req(input int ci, input bit we, input logic [22:0] addr,
                        input logic [7:0] din, input bit err, input bit drop,
                        output int rd_cyc);
    bit got = 0;
    rd_cyc = 0;
    push_exp(ci, we, addr, din, err);
    c_we[ci] = we;
    c_addr[ci*23 +: 23] = addr;
    c_din[ci*8 +: 8] = din;
    c_req[ci] = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (tape_rd) rd_cyc++;
      if (drop && busy) c_req[ci] = 1'b0;
      if (c_ack[ci]) got = 1;
    end
    if (!got) chk("ack_wait", 0, 1);
    c_req[ci] = 1'b0;
    @(negedge clk);
    chk("ack_pulse", 32'(c_ack[ci]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, acks;
    bit seen;
    reset_n = 1'b0;
    c_req = '0; c_we = '0; c_addr = '0; c_din = '0;
    repeat (4) @(negedge clk);
    reset_checks();
    reset_n = 1'b1;
    @(negedge clk);

    // single read from client 0
    rd_data = 8'hA5; rd_delay = 5;
    do_req(0, 1'b0, 23'h012345, 8'h00, 1'b0, 1'b0, cyc);
    chk("t1_dout_hold", 32'(c_dout), 32'hA5);

    // write from client 2, ack gating checked by monitor
    wr_delay = 3;
    do_req(2, 1'b1, 23'h000100, 8'h5A, 1'b0, 1'b0, cyc);

    // round-robin with all three clients writing continuously
    wr_rise = 0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        push_exp(i, 1'b1, 23'(32'h200 + i), 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < N; i++) begin
      c_we[i] = 1'b1;
      c_addr[i*23 +: 23] = 23'(32'h200 + i);
      c_din[i*8 +: 8] = 8'(8'h10 + i);
    end
    c_req = '1;
    acks = 0;
    for (int n = 0; n < 400 && acks < 6; n++) begin
      @(negedge clk);
      if (c_ack != '0) acks++;
    end
    c_req = '0;
    chk("rr_acks", acks, 6);
    @(negedge clk);
    chk("rr_wr_rises", wr_rise, 6);
    chk("rr_sb_empty", sb.size(), 0);

    // read timeout, then a normal read to confirm parity
    ack_en = 1'b0;
    do_req(1, 1'b0, 23'h0ABCDE, 8'h00, 1'b1, 1'b0, cyc);
    chk("tmo_rd_cycles", cyc, 20);
    chk("tmo_dout_kept", 32'(c_dout), 32'hA5);
    ack_en = 1'b1;
    rd_data = 8'h3C; rd_delay = 4;
    do_req(1, 1'b0, 23'h0ABCDF, 8'h00, 1'b0, 1'b0, cyc);

    // reset while a read is outstanding; late toggle must be absorbed
    rd_data = 8'hEE; rd_delay = 2;
    c_we[0] = 1'b0; c_addr[0 +: 23] = 23'h111111; c_req[0] = 1'b1;
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (tape_rd) seen = 1;
    end
    chk("rst_rd_seen", 32'(seen), 1);
    reset_n = 1'b0;
    c_req = '0;
    repeat (6) @(negedge clk);
    reset_checks();
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_busy", 32'(busy), 0);
    rd_data = 8'h77; rd_delay = 4;
    do_req(0, 1'b0, 23'h222222, 8'h00, 1'b0, 1'b0, cyc);
    chk("rst_next_dout", 32'(c_dout), 32'h77);

    // client 1 withdraws its request after grant
    wr_delay = 4;
    do_req(1, 1'b1, 23'h033333, 8'hC3, 1'b0, 1'b1, cyc);
    rd_data = 8'h99; rd_delay = 3;
    do_req(1, 1'b0, 23'h044444, 8'h00, 1'b0, 1'b1, cyc);

    repeat (5) @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
